run_length_detector: RTL and testbench

RUN_LENGTH_DETECTOR -- requirements
Module: run_length_detector

---
 rtl/run_length_detector.sv | 108 ++++++++++
 tb/tb_run_length_detector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// Serial run-length detector. It tracks the polarity and length of the current
// run of identical samples on w, and raises z once the run reaches a
// programmable threshold for a polarity enabled in mode. The flag can either
// follow the run or latch until it is cleared.
module run_length_detector #(
  parameter int CNT_W  = 4,
  parameter int STICKY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
  input  logic [CNT_W-1:0] n,
  input  logic             save,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] run_count,
  output logic [1:0]       current_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ONES  = 2'b01,
    ZEROS = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             z_q, z_d;
  logic             pol_en;
  logic             hit;

  // State, run counter, threshold and flag registers with synchronous reset.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      thr_q   <= CNT_ONE;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      thr_q   <= thr_d;
      z_q     <= z_d;
    end
  end

  // Next-state, run-count, threshold and detect-flag logic.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    thr_d   = thr_q;
    z_d     = z_q;
    pol_en  = 1'b0;
    hit     = 1'b0;

    // A zero threshold would make "run >= thr" meaningless; treat it as 1.
    if (save) begin
      thr_d = (n == '0) ? CNT_ONE : n;
    end

    if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d = w ? ONES : ZEROS;
          cnt_d   = CNT_ONE;
        end
        ONES, ZEROS: begin
          if (w == (state_q == ONES)) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          end else begin
            state_d = (state_q == ONES) ? ZEROS : ONES;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // The hit uses the old threshold: a save on this edge applies next edge.
      pol_en = (state_d == ONES)  ? mode[0] :
               (state_d == ZEROS) ? mode[1] : 1'b0;
      hit    = pol_en && (cnt_d >= thr_q);
    end

    if (STICKY != 0) begin
      // Latched flag: clear only wins when there is no new hit on this edge.
      z_d = hit | (z_q & ~clr);
    end else if (en) begin
      z_d = hit;
    end
  end

  assign z             = z_q;
  assign run_count     = cnt_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector. Two instances share all inputs: one
// with the flag following the run and one with the latched flag.
module tb_run_length_detector;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             w;
  logic [CNT_W-1:0] n;
  logic             save;
  logic [1:0]       mode;
  logic             clr;

  logic             z0, z1;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic [1:0]       st0, st1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_length_detector #(.CNT_W(CNT_W), .STICKY(0)) u_follow (
    .clk(clk), .rst(rst), .en(en), .w(w), .n(n), .save(save), .mode(mode),
    .clr(clr), .z(z0), .run_count(cnt0), .current_state(st0)
  );

  run_length_detector #(.CNT_W(CNT_W), .STICKY(1)) u_sticky (
    .clk(clk), .rst(rst), .en(en), .w(w), .n(n), .save(save), .mode(mode),
    .clr(clr), .z(z1), .run_count(cnt1), .current_state(st1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Load a threshold on an edge with en=0.
  task automatic load(input logic [CNT_W-1:0] val);
    save = 1'b1;
    n    = val;
    tick();
    save = 1'b0;
  endtask

  task automatic cyc(input logic e, input logic b, input logic c);
    en  = e;
    w   = b;
    clr = c;
    tick();
    en  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    logic [4:0] wv;
    logic [4:0] zf;
    logic [4:0] zs;
    rst = 1'b1; en = 1'b0; w = 1'b0; n = '0; save = 1'b0; mode = 2'b00; clr = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_state", st0, 2'b00);
    check("rst_count", cnt0, 0);
    check("rst_z", z0, 0);

    // Threshold 3, runs of ones; save alone leaves run state untouched
    load(4'd3);
    check("save_keeps_count", cnt0, 0);
    check("save_keeps_state", st0, 2'b00);
    mode = 2'b01;
    cyc(1, 1, 0); check("r29_z1", z0, 0); check("r29_c1", cnt0, 1); check("r29_s1", st0, 2'b01);
    cyc(1, 1, 0); check("r29_z2", z0, 0); check("r29_c2", cnt0, 2);
    cyc(1, 1, 0); check("r29_z3", z0, 1); check("r29_c3", cnt0, 3);
    cyc(1, 1, 0); check("r29_z4", z0, 1); check("r29_c4", cnt0, 4);
    // Mode change on a disabled edge is not evaluated
    mode = 2'b00;
    cyc(0, 0, 0); check("hold_z", z0, 1); check("hold_c", cnt0, 4); check("hold_s", st0, 2'b01);
    cyc(1, 1, 0); check("mode00_z", z0, 0); check("mode00_c", cnt0, 5);
    mode = 2'b01;
    cyc(1, 1, 0); check("mode01_z", z0, 1); check("mode01_c", cnt0, 6);
    cyc(1, 0, 0); check("r29_z5", z0, 0); check("r29_c5", cnt0, 1); check("r29_s5", st0, 2'b10);

    // Reset over save/en/clr with z=1, run_count=5
    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);
    check("pre_rst_z", z0, 1);
    check("pre_rst_c", cnt0, 5);
    rst = 1'b1; save = 1'b1; n = 4'd7; en = 1'b1; w = 1'b0; clr = 1'b1;
    tick();
    rst = 1'b0; save = 1'b0; en = 1'b0; clr = 1'b0;
    check("r34_z", z0, 0);
    check("r34_zs", z1, 0);
    check("r34_c", cnt0, 0);
    check("r34_s", st0, 2'b00);
    cyc(1, 1, 0); check("r34_thr1", z0, 1);

    // Save with en on the same edge uses the old threshold (1)
    save = 1'b1; n = 4'd5;
    cyc(1, 1, 0);
    save = 1'b0;
    check("old_thr_z", z0, 1); check("old_thr_c", cnt0, 2);
    cyc(1, 1, 0); check("new_thr_z", z0, 0); check("new_thr_c", cnt0, 3);

    // Threshold 2, runs of zeros only
    do_reset();
    load(4'd2);
    mode = 2'b10;
    cyc(1, 1, 0); check("r30_z1", z0, 0); check("r30_s1", st0, 2'b01);
    cyc(1, 0, 0); check("r30_z2", z0, 0); check("r30_s2", st0, 2'b10);
    cyc(1, 0, 0); check("r30_z3", z0, 1); check("r30_s3", st0, 2'b10);
    cyc(1, 0, 0); check("r30_z4", z0, 1); check("r30_s4", st0, 2'b10);

    // n=0 loads as 1; both polarities enabled
    do_reset();
    load(4'd0);
    mode = 2'b11;
    cyc(1, 1, 0); check("r31_z1", z0, 1);
    cyc(1, 0, 0); check("r31_z2", z0, 1); check("r31_c2", cnt0, 1);

    // Saturation at 15 with threshold 15
    do_reset();
    load(4'd15);
    mode = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 1, 0);
      check($sformatf("sat_c%0d", i), cnt0, (i > 15) ? 15 : i);
      check($sformatf("sat_z%0d", i), z0, (i >= 15) ? 1 : 0);
    end

    // Latched flag: threshold 2, w=1,1,0,0,0
    do_reset();
    load(4'd2);
    mode = 2'b01;
    wv = 5'b00011;  // bit i is sample i
    zf = 5'b00010;
    zs = 5'b11110;
    for (int i = 0; i < 5; i++) begin
      cyc(1, wv[i], 0);
      check($sformatf("r33_zs%0d", i + 1), z1, zs[i]);
      check($sformatf("r33_zf%0d", i + 1), z0, zf[i]);
    end
    cyc(0, 0, 1); check("r33_clr", z1, 0); check("r33_clr_follow", z0, 0);
    cyc(1, 1, 0); check("stk_new_run", z1, 0);
    cyc(1, 1, 0); check("stk_hit", z1, 1);
    cyc(1, 1, 1); check("stk_clr_hit", z1, 1);
    cyc(0, 1, 0); check("stk_hold", z1, 1); check("follow_hold", z0, 1);
    cyc(1, 0, 1); check("stk_clr_nohit", z1, 0); check("stk_c", cnt1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
